// File: rtl/sar_search_ctrl_if.sv
// Comparator-side bus of the successive-approximation search engine.
// The master is the search engine: it drives the probe operand and reports
// search status; the slave is the comparator/consumer environment.
interface sar_search_ctrl_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic [WIDTH-1:0] guess;
    logic             cmp_greater;
    logic             cmp_equal;
    logic             cmp_less;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             found;
    logic             error;

    modport master (
        input  start,
        input  cmp_greater,
        input  cmp_equal,
        input  cmp_less,
        output guess,
        output busy,
        output done,
        output result,
        output found,
        output error
    );

    modport slave (
        output start,
        output cmp_greater,
        output cmp_equal,
        output cmp_less,
        input  guess,
        input  busy,
        input  done,
        input  result,
        input  found,
        input  error
    );
endinterface

// File: rtl/sar_search_ctrl.sv
// Successive-approximation search engine. Drives the A operand of an external
// magnitude comparator one bit per cycle, MSB first, and reads back the
// greater/equal/less verdict to locate the unknown B value. Exits early on an
// equal verdict, otherwise confirms the final guess in a VERIFY probe.
module sar_search_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    sar_search_ctrl_if.master bus
);

    localparam int               IDXW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [WIDTH-1:0] GUESS_INIT = WIDTH'(1) << (WIDTH - 1);
    localparam logic [IDXW-1:0]  IDX_INIT   = IDXW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        TRIAL  = 2'd1,
        VERIFY = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] guess_q;
    logic [WIDTH-1:0] result_q;
    logic [IDXW-1:0]  idx_q;
    logic             busy_q;
    logic             done_q;
    logic             found_q;
    logic             error_q;

    logic             gt;
    logic             eq;
    logic             lt;
    logic             onehot;
    logic [WIDTH-1:0] guess_d;

    assign gt = bus.cmp_greater;
    assign eq = bus.cmp_equal;
    assign lt = bus.cmp_less;

    // Verdict is trustworthy only when exactly one of gt/eq/lt is set.
    always_comb begin
        onehot = (gt & ~eq & ~lt) | (~gt & eq & ~lt) | (~gt & ~eq & lt);
    end

    // Next trial guess: clear bit idx on "too big", then seed bit idx-1.
    // Pure bit set/clear, no arithmetic on the operand itself.
    always_comb begin
        guess_d = guess_q;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if ((IDXW'(i) == idx_q) && gt) begin
                guess_d[i] = 1'b0;
            end
            if ((i + 1 < WIDTH) && (IDXW'(i + 1) == idx_q)) begin
                guess_d[i] = 1'b1;
            end
        end
    end

    // Search FSM with all outputs registered; done is a one-cycle pulse
    // that coincides with the return to IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            guess_q  <= '0;
            result_q <= '0;
            idx_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            found_q  <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        guess_q <= GUESS_INIT;
                        idx_q   <= IDX_INIT;
                        busy_q  <= 1'b1;
                        found_q <= 1'b0;
                        error_q <= 1'b0;
                        state_q <= TRIAL;
                    end
                end
                TRIAL: begin
                    if (!onehot) begin
                        error_q <= 1'b1;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                    end else if (eq) begin
                        result_q <= guess_q;
                        found_q  <= 1'b1;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        state_q  <= IDLE;
                    end else begin
                        guess_q <= guess_d;
                        if (idx_q == '0) begin
                            state_q <= VERIFY;
                        end else begin
                            idx_q <= idx_q - IDXW'(1);
                        end
                    end
                end
                VERIFY: begin
                    result_q <= guess_q;
                    if (onehot && eq) begin
                        found_q <= 1'b1;
                    end else begin
                        error_q <= 1'b1;
                    end
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.guess  = guess_q;
    assign bus.result = result_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.found  = found_q;
    assign bus.error  = error_q;

endmodule
